// File: rtl/adder_sched.sv
// Round-robin sequencer for the shared 32-bit adder: runs 32-bit ops in one pass
// and 64-bit ops in two chained passes, then holds the result on a valid/ready channel.
module adder_sched #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [1:0]           req0_op,
    input  logic [2*WIDTH-1:0]   req0_a,
    input  logic [2*WIDTH-1:0]   req0_b,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [1:0]           req1_op,
    input  logic [2*WIDTH-1:0]   req1_a,
    input  logic [2*WIDTH-1:0]   req1_b,

    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_cin,
    input  logic [WIDTH-1:0]     add_s,
    input  logic [WIDTH-1:0]     add_p,
    input  logic [WIDTH-1:0]     add_g,
    input  logic                 add_ovf,

    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_id,
    output logic [2*WIDTH-1:0]   resp_data,
    output logic                 resp_cout,
    output logic                 resp_ovf
);

    localparam int unsigned DW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_gnt;
    logic              take_c;
    logic              gnt_c;
    logic [1:0]        op_q;
    logic [DW-1:0]     a_q;
    logic [DW-1:0]     b_q;
    logic              pass_cout_c;
    logic              unused_pg;

    // op_q[0] selects SUB, op_q[1] selects the 64-bit two-pass sequence
    wire sub_q  = op_q[0];
    wire wide_q = op_q[1];

    // The adder has no carry-out port; rebuild it from bit 31 (s ^ p recovers the carry into bit 31)
    assign pass_cout_c = add_g[WIDTH-1] | (add_p[WIDTH-1] & (add_s[WIDTH-1] ^ add_p[WIDTH-1]));
    assign unused_pg   = ^{add_p[WIDTH-2:0], add_g[WIDTH-2:0]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, grant and adder drive
    always_comb begin
        state_nxt  = state;
        take_c     = 1'b0;
        gnt_c      = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        add_a      = '0;
        add_b      = '0;
        add_cin    = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n && (req0_valid || req1_valid)) begin
                    take_c     = 1'b1;
                    gnt_c      = (req0_valid && req1_valid) ? ~last_gnt : req1_valid;
                    req0_ready = ~gnt_c;
                    req1_ready = gnt_c;
                    state_nxt  = LO;
                end
            end
            LO: begin
                add_a     = a_q[WIDTH-1:0];
                add_b     = sub_q ? ~b_q[WIDTH-1:0] : b_q[WIDTH-1:0];
                add_cin   = sub_q;
                state_nxt = wide_q ? HI : RESP;
            end
            HI: begin
                // resp_cout still holds the low-pass carry here
                add_a     = a_q[DW-1:WIDTH];
                add_b     = sub_q ? ~b_q[DW-1:WIDTH] : b_q[DW-1:WIDTH];
                add_cin   = resp_cout;
                state_nxt = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request capture, pass results and response flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt   <= 1'b1;
            op_q       <= 2'b00;
            a_q        <= '0;
            b_q        <= '0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_data  <= '0;
            resp_cout  <= 1'b0;
            resp_ovf   <= 1'b0;
        end else begin
            resp_valid <= (state_nxt == RESP);
            if (take_c) begin
                last_gnt <= gnt_c;
                resp_id  <= gnt_c;
                op_q     <= gnt_c ? req1_op : req0_op;
                a_q      <= gnt_c ? req1_a  : req0_a;
                b_q      <= gnt_c ? req1_b  : req0_b;
            end
            if (state == LO) begin
                resp_data <= {WIDTH'(0), add_s};
                resp_cout <= pass_cout_c;
                resp_ovf  <= add_ovf;
            end
            if (state == HI) begin
                resp_data[DW-1:WIDTH] <= add_s;
                resp_cout             <= pass_cout_c;
                resp_ovf              <= add_ovf;
            end
        end
    end

endmodule

// File: tb/tb_adder_sched.sv
// Scoreboard bench for adder_sched with a behavioural model of the 32-bit adder.
module tb_adder_sched;

    localparam int unsigned W  = 32;
    localparam int unsigned DW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]    req0_op, req1_op;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [W-1:0]  add_a, add_b, add_s, add_p, add_g;
    logic          add_cin, add_ovf;
    logic          resp_valid, resp_ready, resp_id, resp_cout, resp_ovf;
    logic [DW-1:0] resp_data;
    logic [W:0]    sum33;

    typedef struct packed {
        logic          id;
        logic [DW-1:0] data;
        logic          cout;
        logic          ovf;
    } exp_t;

    exp_t sb[$];
    exp_t got_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   kc = 0;

    adder_sched #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_p(add_p), .add_g(add_g), .add_ovf(add_ovf),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_cout(resp_cout), .resp_ovf(resp_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational CLA stand-in: overflow is carry-into-msb xor carry-out
    always_comb begin
        sum33   = {1'b0, add_a} + {1'b0, add_b} + 33'(add_cin);
        add_s   = sum33[W-1:0];
        add_p   = add_a ^ add_b;
        add_g   = add_a & add_b;
        add_ovf = sum33[W] ^ (add_a[W-1] ^ add_b[W-1] ^ sum33[W-1]);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic id, input logic [1:0] op,
                                   input logic [63:0] a, input logic [63:0] b);
        exp_t        e;
        logic [64:0] s;
        logic [32:0] t;
        logic [63:0] bb;
        bb   = op[0] ? ~b : b;
        e.id = id;
        if (op[1]) begin
            s      = {1'b0, a} + {1'b0, bb} + 65'(op[0]);
            e.data = s[63:0];
            e.cout = s[64];
            e.ovf  = (a[63] == bb[63]) && (s[63] != a[63]);
        end else begin
            t      = {1'b0, a[31:0]} + {1'b0, bb[31:0]} + 33'(op[0]);
            e.data = {32'h0, t[31:0]};
            e.cout = t[32];
            e.ovf  = (a[31] == bb[31]) && (t[31] != a[31]);
        end
        return e;
    endfunction

    // Push on request handshake, pop and compare on response handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (req0_valid && req0_ready) sb.push_back(model(1'b0, req0_op, req0_a, req0_b));
            if (req1_valid && req1_ready) sb.push_back(model(1'b1, req1_op, req1_a, req1_b));
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'd1, 64'd0);
                end else begin
                    got_e = sb.pop_front();
                    check("sb_id",   64'(resp_id),   64'(got_e.id));
                    check("sb_data", resp_data,      got_e.data);
                    check("sb_cout", 64'(resp_cout), 64'(got_e.cout));
                    check("sb_ovf",  64'(resp_ovf),  64'(got_e.ovf));
                end
            end
        end
    end

    task automatic send(input int port, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        if (port == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if ((port == 0) ? req0_ready : req1_ready) got = 1'b1;
        end
        if (!got) check("send_timeout", 64'd1, 64'd0);
        kc = cyc;
        @(posedge clk); #1;
        if (port == 0) req0_valid = 1'b0;
        else           req1_valid = 1'b0;
    endtask

    task automatic wait_resp(input int lat);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (resp_valid) got = 1'b1;
        end
        if (!got) check("resp_timeout", 64'd1, 64'd0);
        else      check("latency", 64'(cyc - kc), 64'(lat));
    endtask

    task automatic expect_resp(input int lat, input logic id, input logic [63:0] data,
                               input logic cout, input logic ovf);
        wait_resp(lat);
        check("resp_id",   64'(resp_id),   64'(id));
        check("resp_data", resp_data,      data);
        check("resp_cout", 64'(resp_cout), 64'(cout));
        check("resp_ovf",  64'(resp_ovf),  64'(ovf));
    endtask

    logic [1:0]  tbl_op [4] = '{2'b10, 2'b11, 2'b10, 2'b11};
    logic [63:0] tbl_a  [4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
    logic [63:0] tbl_b  [4] = '{64'h1, 64'h1, 64'h1, 64'h1};

    initial begin
        int          n0, n1, nr;
        logic        ids [4];
        logic [1:0]  rop;
        logic [63:0] ra, rb;
        logic [3:0]  exp_ids;

        req0_valid = 1'b1; req0_op = 2'b00; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 2'b00; req1_a = '0; req1_b = '0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_valid", 64'(resp_valid), 64'd0);
        check("rst_r0",    64'(req0_ready), 64'd0);
        check("rst_r1",    64'(req1_ready), 64'd0);
        check("rst_id",    64'(resp_id),    64'd0);
        check("rst_data",  resp_data,       64'd0);
        check("rst_flags", 64'({resp_cout, resp_ovf}), 64'd0);
        check("rst_add",   {add_a, add_b},  64'd0);
        check("rst_cin",   64'(add_cin),    64'd0);
        req0_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        resp_ready = 1'b1;

        send(0, 2'b00, 64'h7FFF_FFFF, 64'h1);
        expect_resp(2, 1'b0, 64'h0000_0000_8000_0000, 1'b0, 1'b1);
        send(0, 2'b01, 64'd5, 64'd7);
        expect_resp(2, 1'b0, 64'h0000_0000_FFFF_FFFE, 1'b0, 1'b0);
        send(1, 2'b01, 64'd7, 64'd5);
        expect_resp(2, 1'b1, 64'd2, 1'b1, 1'b0);

        send(0, 2'b10, 64'h0000_0000_FFFF_FFFF, 64'h1);
        @(negedge clk);
        check("lo_add_a", 64'(add_a),   64'hFFFF_FFFF);
        check("lo_cin",   64'(add_cin), 64'd0);
        @(negedge clk);
        check("hi_cin",   64'(add_cin), 64'd1);
        check("hi_add_a", 64'(add_a),   64'd0);
        expect_resp(3, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0);

        // Backpressure with req1 waiting
        @(posedge clk); #1;
        resp_ready = 1'b0;
        send(0, 2'b00, 64'h1234_5678, 64'h1111_1111);
        req1_valid = 1'b1; req1_op = 2'b00; req1_a = 64'h100; req1_b = 64'h23;
        wait_resp(2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(resp_valid), 64'd1);
            check("bp_data",  resp_data,       64'h2345_6789);
            check("bp_rdy",   64'({req0_ready, req1_ready}), 64'd0);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_grant", 64'(req1_ready), 64'd1);
        kc = cyc;
        @(posedge clk); #1;
        req1_valid = 1'b0;
        expect_resp(2, 1'b1, 64'h123, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            send(i % 2, tbl_op[i], tbl_a[i], tbl_b[i]);
            wait_resp(tbl_op[i][1] ? 3 : 2);
        end
        for (int i = 0; i < 16; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            send(int'($urandom_range(0, 1)), rop, ra, rb);
            wait_resp(rop[1] ? 3 : 2);
        end

        // Round-robin after a fresh reset
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 64'd10;  req0_b = 64'd20;
        req1_valid = 1'b1; req1_op = 2'b00; req1_a = 64'd100; req1_b = 64'd200;
        n0 = 0; n1 = 0; nr = 0;
        for (int i = 0; i < 40 && nr < 4; i++) begin
            @(negedge clk);
            if (req0_ready) n0++;
            if (req1_ready) n1++;
            if (resp_valid && resp_ready) begin
                ids[nr] = resp_id;
                nr++;
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("arb_count", 64'(nr), 64'd4);
        exp_ids = 4'b1010;
        for (int i = 0; i < nr && i < 4; i++) check("arb_order", 64'(ids[i]), 64'(exp_ids[i]));
        check("arb_r0_pulses", 64'(n0), 64'd2);
        check("arb_r1_pulses", 64'(n1), 64'd2);

        // Reset during the high pass of an ADD64
        send(0, 2'b10, 64'h0000_0001_0000_0005, 64'd3);
        @(posedge clk); #1;
        check("pre_rst_hi_a", 64'(add_a), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(resp_valid), 64'd0);
        check("mid_rst_data",  resp_data,       64'd0);
        check("mid_rst_add",   {add_a, add_b},  64'd0);
        check("mid_rst_misc",  64'({add_cin, resp_cout, resp_ovf, resp_id, req0_ready, req1_ready}), 64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_resp", 64'(resp_valid), 64'd0);
        end
        send(0, 2'b00, 64'h40, 64'h2);
        expect_resp(2, 1'b0, 64'h42, 1'b0, 1'b0);
        @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

endmodule
